// File: rtl/slv_guard_cfg_seq.sv
// slv_guard_cfg_seq: register-bus master that brings up the slave guard (enable, write budget,
// read budget) and services its interrupt: read status, write-1-to-clear, request a subordinate
// reset, wait for the acknowledge, then reconfigure from scratch.
// Optional feature macro: SLV_GUARD_CFG_TIMEOUT_EN adds a per-access ready timeout of
// TimeoutCycles; an expired wait is handled like an errored completion.
module slv_guard_cfg_seq #(
  parameter int unsigned          AddrWidth   = 32,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  parameter logic [DataWidth-1:0] WriteBudget = DataWidth'(1),
  parameter logic [DataWidth-1:0] ReadBudget  = DataWidth'(1),
  parameter int unsigned          MaxRetries  = 3
`ifdef SLV_GUARD_CFG_TIMEOUT_EN
  ,
  parameter int unsigned          TimeoutCycles = 64
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 irq_i,
  input  logic                 rst_ack_i,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic [DataWidth-1:0] reg_wdata_o,
  output logic [3:0]           reg_wstrb_o,
  output logic                 reg_write_o,
  output logic                 reg_valid_o,
  input  logic [DataWidth-1:0] reg_rdata_i,
  input  logic                 reg_ready_i,
  input  logic                 reg_error_i,
  output logic                 configured_o,
  output logic                 busy_o,
  output logic [DataWidth-1:0] irq_status_o,
  output logic                 rst_req_o,
  output logic                 err_o
);

  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MaxRetries);

  typedef enum logic [3:0] {
    StIdle,
    StWrEn,
    StWrWb,
    StWrRb,
    StRun,
    StRdIrq,
    StClrIrq,
    StRstReq,
    StError
  } state_e;

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic                   write_q, write_d;
  logic [3:0]             strb_q, strb_d;
  logic [RetryW-1:0]      retry_q, retry_d;
  logic [DataWidth-1:0]   status_q, status_d;

  // Access descriptor for the current state.
  logic [AddrWidth-1:0]   acc_addr;
  logic [DataWidth-1:0]   acc_wdata;
  logic                   acc_write;
  state_e                 acc_next;
  logic                   acc_done;
  logic                   acc_err;
  logic                   tmo_hit;

`ifdef SLV_GUARD_CFG_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  assign tmo_hit = valid_q & ~reg_ready_i & (tmo_q == TmoW'(TimeoutCycles - 1));

  // Wait-cycle counter for the current attempt; held at zero while valid is low.
  always_comb begin
    tmo_d = tmo_q;
    if (!valid_q) begin
      tmo_d = '0;
    end else if (!reg_ready_i && !tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // A timeout ends the attempt exactly like an errored ready.
  assign acc_done = valid_q & (reg_ready_i | tmo_hit);
  assign acc_err  = (reg_ready_i & reg_error_i) | tmo_hit;

  // Decode the register access and successor state for each access state.
  always_comb begin
    acc_addr  = BaseAddr;
    acc_wdata = '0;
    acc_write = 1'b1;
    acc_next  = StIdle;
    case (state_q)
      StWrEn: begin
        acc_wdata = DataWidth'(1);
        acc_next  = StWrWb;
      end
      StWrWb: begin
        acc_addr  = BaseAddr + AddrWidth'(4);
        acc_wdata = WriteBudget;
        acc_next  = StWrRb;
      end
      StWrRb: begin
        acc_addr  = BaseAddr + AddrWidth'(8);
        acc_wdata = ReadBudget;
        acc_next  = StRun;
      end
      StRdIrq: begin
        acc_addr  = BaseAddr + AddrWidth'(12);
        acc_write = 1'b0;
        acc_next  = StClrIrq;
      end
      StClrIrq: begin
        acc_addr  = BaseAddr + AddrWidth'(12);
        acc_wdata = status_q;
        acc_next  = StRstReq;
      end
      default: ;
    endcase
  end

  // Next-state logic. Every access state is entered with valid low, so the first cycle there
  // is the setup/gap cycle and the request rises on the following edge.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    strb_d   = strb_q;
    retry_d  = retry_q;
    status_d = status_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StWrEn;
        end
      end
      StRun: begin
        if (irq_i) begin
          state_d = StRdIrq;
        end
      end
      StRstReq: begin
        if (rst_ack_i) begin
          state_d = StWrEn;
        end
      end
      StWrEn, StWrWb, StWrRb, StRdIrq, StClrIrq: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          addr_d  = acc_addr;
          wdata_d = acc_wdata;
          write_d = acc_write;
          strb_d  = acc_write ? 4'hF : 4'h0;
        end else if (acc_done) begin
          valid_d = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          write_d = 1'b0;
          strb_d  = 4'h0;
          if (acc_err) begin
            if (retry_q < RetryMax) begin
              // Stay put; the same access is re-issued after the gap cycle.
              retry_d = retry_q + 1'b1;
            end else begin
              state_d = StError;
            end
          end else begin
            retry_d = '0;
            state_d = acc_next;
            if (state_q == StRdIrq) begin
              status_d = reg_rdata_i;
            end
          end
        end
      end
      StError: ;
      default: state_d = StIdle;
    endcase
  end

  // State and bus register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      strb_q   <= 4'h0;
      retry_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      strb_q   <= strb_d;
      retry_q  <= retry_d;
      status_q <= status_d;
    end
  end

  assign reg_valid_o  = valid_q;
  assign reg_addr_o   = addr_q;
  assign reg_wdata_o  = wdata_q;
  assign reg_write_o  = write_q;
  assign reg_wstrb_o  = strb_q;
  assign irq_status_o = status_q;
  assign configured_o = (state_q == StRun);
  assign rst_req_o    = (state_q == StRstReq);
  assign err_o        = (state_q == StError);
  assign busy_o       = (state_q != StIdle) && (state_q != StRun) && (state_q != StError);

endmodule

// File: tb/tb_slv_guard_cfg_seq.sv
// Testbench for slv_guard_cfg_seq: a randomised register slave logs every access attempt and
// the expected access sequence and latencies are derived from the guard bring-up rules.
module tb_slv_guard_cfg_seq;

  localparam logic [31:0] Base = 32'h4000_0100;
  localparam logic [31:0] Wb   = 32'h0000_0a5c;
  localparam logic [31:0] Rb   = 32'h0000_3c71;
  localparam int          MaxRetries = 3;

  logic        clk = 1'b0;
  logic        rst_i, start_i, irq_i, rst_ack_i;
  logic [31:0] reg_addr_o, reg_wdata_o, reg_rdata_i, irq_status_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_write_o, reg_valid_o, reg_ready_i, reg_error_i;
  logic        configured_o, busy_o, rst_req_o, err_o;

  always #5 clk = ~clk;

  slv_guard_cfg_seq #(
    .AddrWidth  (32),
    .DataWidth  (32),
    .BaseAddr   (Base),
    .WriteBudget(Wb),
    .ReadBudget (Rb),
    .MaxRetries (MaxRetries)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .irq_i       (irq_i),
    .rst_ack_i   (rst_ack_i),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wstrb_o (reg_wstrb_o),
    .reg_write_o (reg_write_o),
    .reg_valid_o (reg_valid_o),
    .reg_rdata_i (reg_rdata_i),
    .reg_ready_i (reg_ready_i),
    .reg_error_i (reg_error_i),
    .configured_o(configured_o),
    .busy_o      (busy_o),
    .irq_status_o(irq_status_o),
    .rst_req_o   (rst_req_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr;
    logic [3:0]  strb;
  } acc_t;

  acc_t        log_q[$];
  acc_t        exp_q[$];
  bit          err_plan[$];
  int          slv_delay = 0;
  bit          slv_junk = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          stab_viol = 0;
  int          gap_viol = 0;
  int          checks = 0;
  int          errors = 0;

  // Register slave: answers after slv_delay wait cycles, logs each attempt, watches stability.
  initial begin : slave
    int   waited;
    bit   just_done;
    bit   e;
    acc_t cur;
    waited = 0;
    just_done = 1'b0;
    cur = '0;
    reg_ready_i = 1'b0;
    reg_error_i = 1'b0;
    reg_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      reg_ready_i = 1'b0;
      reg_error_i = 1'b0;
      if (reg_valid_o === 1'b1 && just_done) gap_viol++;
      just_done = 1'b0;
      if (reg_valid_o === 1'b1) begin
        if (waited == 0) begin
          cur.addr = reg_addr_o;
          cur.data = reg_write_o ? reg_wdata_o : 32'h0;
          cur.wr   = reg_write_o;
          cur.strb = reg_wstrb_o;
        end else if (reg_addr_o !== cur.addr || reg_write_o !== cur.wr ||
                     reg_wstrb_o !== cur.strb || (cur.wr && reg_wdata_o !== cur.data)) begin
          stab_viol++;
        end
        if (waited >= slv_delay) begin
          e = (err_plan.size() > 0) ? err_plan.pop_front() : 1'b0;
          reg_ready_i = 1'b1;
          reg_error_i = e;
          reg_rdata_i = cur.wr ? $urandom : slv_rdata;
          log_q.push_back(cur);
          waited = 0;
          just_done = 1'b1;
        end else begin
          waited++;
        end
      end else begin
        waited = 0;
        // Stray ready between accesses must be ignored by the master.
        if (slv_junk) reg_ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d, required finish", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic acc_t mk(logic [31:0] a, logic [31:0] d, logic w);
    acc_t r;
    r.addr = a;
    r.data = w ? d : 32'h0;
    r.wr   = w;
    r.strb = w ? 4'hF : 4'h0;
    return r;
  endfunction

  function automatic void push_cfg();
    exp_q.push_back(mk(Base, 32'h1, 1'b1));
    exp_q.push_back(mk(Base + 32'h4, Wb, 1'b1));
    exp_q.push_back(mk(Base + 32'h8, Rb, 1'b1));
  endfunction

  // Latency in cycles from the triggering edge: one setup cycle, all attempts, one gap between
  // consecutive attempts, and the cycle in which the target state is visible.
  function automatic int exp_lat(int d, int n_acc, int n_err);
    int n;
    n = n_acc + n_err;
    return 1 + n * (d + 1) + (n - 1) + 1;
  endfunction

  function automatic int first_diff();
    int n;
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (log_q[i] !== exp_q[i]) return i;
    if (log_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic acc_t log_at(int i);
    return (i >= 0 && i < log_q.size()) ? log_q[i] : '0;
  endfunction

  function automatic acc_t exp_at(int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : '0;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    start_i = 1'b0;
    irq_i = 1'b0;
    rst_ack_i = 1'b0;
    slv_junk = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    log_q.delete();
    exp_q.delete();
    err_plan.delete();
    stab_viol = 0;
    gap_viol = 0;
  endtask

  task automatic wait_cfg(output int lat);
    lat = 1;
    while (configured_o !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (configured_o !== 1'b1) lat = -1;
  endtask

  task automatic start_and_wait(output int lat);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_cfg(lat);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({reg_valid_o, reg_write_o, reg_wstrb_o, configured_o, busy_o, rst_req_o, err_o,
         reg_addr_o, reg_wdata_o, irq_status_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b addr=%h wdata=%h strb=%h busy=%b cfg=%b err=%b, want all 0",
               reg_valid_o, reg_addr_o, reg_wdata_o, reg_wstrb_o, busy_o, configured_o, err_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || reg_valid_o !== 1'b0 || log_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b valid=%b accesses=%0d, want 0 0 0",
               busy_o, reg_valid_o, log_q.size());
    end
  endtask

  task automatic test_config_zero_wait();
    int lat, idx;
    do_reset();
    slv_delay = 0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || reg_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL cfg_setup: busy=%b valid=%b, want 1 0", busy_o, reg_valid_o);
    end
    wait_cfg(lat);
    checks++;
    if (lat !== exp_lat(0, 3, 0)) begin
      errors++;
      $display("FAIL cfg0_latency: got %0d cycles, want %0d", lat, exp_lat(0, 3, 0));
    end
    push_cfg();
    idx = first_diff();
    checks++;
    if (idx !== -1) begin
      errors++;
      $display("FAIL cfg0_log: entry %0d got %h want %h (%0d vs %0d entries)",
               idx, log_at(idx), exp_at(idx), log_q.size(), exp_q.size());
    end
    checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b0 || stab_viol != 0 || gap_viol != 0) begin
      errors++;
      $display("FAIL cfg0_status: busy=%b err=%b stab=%0d gap=%0d, want 0 0 0 0",
               busy_o, err_o, stab_viol, gap_viol);
    end
  endtask

  task automatic test_config_wait();
    int lat, idx, d;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      d = (it == 0) ? 3 : $urandom_range(1, 6);
      slv_delay = d;
      slv_junk = 1'b1;
      start_and_wait(lat);
      checks++;
      if (lat !== exp_lat(d, 3, 0)) begin
        errors++;
        $display("FAIL cfgw_latency: delay %0d got %0d cycles, want %0d", d, lat, exp_lat(d, 3, 0));
      end
      push_cfg();
      idx = first_diff();
      checks++;
      if (idx !== -1) begin
        errors++;
        $display("FAIL cfgw_log: delay %0d entry %0d got %h want %h", d, idx, log_at(idx), exp_at(idx));
      end
      checks++;
      if (stab_viol != 0 || gap_viol != 0) begin
        errors++;
        $display("FAIL cfgw_handshake: stability violations %0d gap violations %0d, want 0 0",
                 stab_viol, gap_viol);
      end
    end
  endtask

  task automatic test_retry();
    int lat, idx, d;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      d = $urandom_range(0, 3);
      slv_delay = d;
      for (int j = 0; j < k; j++) err_plan.push_back(1'b0);
      err_plan.push_back(1'b1);
      start_and_wait(lat);
      checks++;
      if (lat !== exp_lat(d, 3, 1)) begin
        errors++;
        $display("FAIL retry_latency: access %0d got %0d cycles, want %0d", k, lat, exp_lat(d, 3, 1));
      end
      push_cfg();
      exp_q.insert(k, exp_q[k]);
      idx = first_diff();
      checks++;
      if (idx !== -1) begin
        errors++;
        $display("FAIL retry_log: access %0d entry %0d got %h want %h", k, idx, log_at(idx), exp_at(idx));
      end
      checks++;
      if (err_o !== 1'b0 || gap_viol != 0) begin
        errors++;
        $display("FAIL retry_err: err=%b gap=%0d, want 0 0", err_o, gap_viol);
      end
    end
  endtask

  task automatic test_fatal();
    int lat, idx, d, bad;
    do_reset();
    d = $urandom_range(0, 2);
    slv_delay = d;
    repeat (8) err_plan.push_back(1'b1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    while (err_o !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (err_o !== 1'b1) lat = -1;
    checks++;
    // Four attempts of the enable write, three gaps, then ERROR is visible.
    if (lat !== exp_lat(d, 1, MaxRetries)) begin
      errors++;
      $display("FAIL fatal_latency: got %0d cycles, want %0d", lat, exp_lat(d, 1, MaxRetries));
    end
    for (int i = 0; i <= MaxRetries; i++) exp_q.push_back(mk(Base, 32'h1, 1'b1));
    idx = first_diff();
    checks++;
    if (idx !== -1) begin
      errors++;
      $display("FAIL fatal_log: entry %0d got %h want %h (%0d vs %0d entries)",
               idx, log_at(idx), exp_at(idx), log_q.size(), exp_q.size());
    end
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      start_i = (c == 4);
      rst_ack_i = (c == 6);
      @(negedge clk);
      if ({reg_valid_o, reg_write_o, reg_wstrb_o, reg_addr_o, reg_wdata_o, busy_o,
           configured_o} !== '0 || err_o !== 1'b1) bad++;
    end
    start_i = 1'b0;
    rst_ack_i = 1'b0;
    checks++;
    if (bad != 0 || log_q.size() != MaxRetries + 1) begin
      errors++;
      $display("FAIL fatal_sticky: bad cycles %0d accesses %0d, want 0 and %0d",
               bad, log_q.size(), MaxRetries + 1);
    end
    do_reset();
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL fatal_clear: err=%b after reset, want 0", err_o);
    end
  endtask

  task automatic test_irq();
    int lat, idx, d, dropped;
    logic [31:0] status;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      d = $urandom_range(0, 3);
      slv_delay = d;
      start_and_wait(lat);
      log_q.delete();
      rst_ack_i = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      rst_ack_i = 1'b0;
      start_i = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      checks++;
      if (configured_o !== 1'b1 || log_q.size() != 0) begin
        errors++;
        $display("FAIL run_ignore: configured=%b accesses=%0d, want 1 0", configured_o, log_q.size());
      end
      status = (it == 0) ? 32'h5 : $urandom;
      slv_rdata = status;
      irq_i = 1'b1;
      @(negedge clk);
      checks++;
      if (configured_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL irq_leave_run: configured=%b busy=%b, want 0 1", configured_o, busy_o);
      end
      lat = 1;
      while (rst_req_o !== 1'b1 && lat < 400) begin
        @(negedge clk);
        lat++;
      end
      if (rst_req_o !== 1'b1) lat = -1;
      irq_i = 1'b0;
      checks++;
      if (lat !== exp_lat(d, 2, 0)) begin
        errors++;
        $display("FAIL irq_latency: got %0d cycles to rst_req, want %0d", lat, exp_lat(d, 2, 0));
      end
      checks++;
      if (irq_status_o !== status) begin
        errors++;
        $display("FAIL irq_status: got %h, want %h", irq_status_o, status);
      end
      dropped = 0;
      repeat ($urandom_range(1, 6)) begin
        @(negedge clk);
        if (rst_req_o !== 1'b1 || reg_valid_o !== 1'b0) dropped++;
      end
      checks++;
      if (dropped != 0) begin
        errors++;
        $display("FAIL rst_req_hold: %0d cycles without request or with bus activity, want 0", dropped);
      end
      rst_ack_i = 1'b1;
      @(negedge clk);
      rst_ack_i = 1'b0;
      wait_cfg(lat);
      checks++;
      if (lat !== exp_lat(d, 3, 0) || rst_req_o !== 1'b0) begin
        errors++;
        $display("FAIL reconfig: got %0d cycles rst_req=%b, want %0d cycles rst_req=0",
                 lat, rst_req_o, exp_lat(d, 3, 0));
      end
      exp_q.push_back(mk(Base + 32'hC, 32'h0, 1'b0));
      exp_q.push_back(mk(Base + 32'hC, status, 1'b1));
      push_cfg();
      idx = first_diff();
      checks++;
      if (idx !== -1) begin
        errors++;
        $display("FAIL irq_log: entry %0d got %h want %h (%0d vs %0d entries)",
                 idx, log_at(idx), exp_at(idx), log_q.size(), exp_q.size());
      end
    end
  endtask

  task automatic test_back_to_back_irq();
    int lat, idx, d, n;
    logic [31:0] status;
    do_reset();
    d = $urandom_range(0, 3);
    slv_delay = d;
    status = $urandom;
    slv_rdata = status;
    // Interrupt already high during bring-up: only RUN samples it, so RUN lasts one cycle.
    irq_i = 1'b1;
    start_and_wait(lat);
    checks++;
    if (lat !== exp_lat(d, 3, 0)) begin
      errors++;
      $display("FAIL early_irq_cfg: got %0d cycles, want %0d", lat, exp_lat(d, 3, 0));
    end
    n = 0;
    while (configured_o === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL early_irq_run: configured for %0d cycles, want 1", n);
    end
    n = 0;
    while (rst_req_o !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    irq_i = 1'b0;
    rst_ack_i = 1'b1;
    @(negedge clk);
    rst_ack_i = 1'b0;
    wait_cfg(lat);
    push_cfg();
    exp_q.push_back(mk(Base + 32'hC, 32'h0, 1'b0));
    exp_q.push_back(mk(Base + 32'hC, status, 1'b1));
    push_cfg();
    idx = first_diff();
    checks++;
    if (idx !== -1 || lat !== exp_lat(d, 3, 0)) begin
      errors++;
      $display("FAIL early_irq_log: entry %0d got %h want %h, reconfig %0d cycles want %0d",
               idx, log_at(idx), exp_at(idx), lat, exp_lat(d, 3, 0));
    end
  endtask

  task automatic test_mid_reset();
    int lat, idx, n;
    do_reset();
    slv_delay = 5;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(reg_valid_o === 1'b1 && reg_addr_o === Base + 32'h4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL midrst_reach: write budget access not seen within %0d cycles, want seen", n);
    end
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({reg_valid_o, reg_write_o, reg_wstrb_o, configured_o, busy_o, rst_req_o, err_o,
         reg_addr_o, reg_wdata_o, irq_status_o} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b addr=%h wdata=%h strb=%h busy=%b, want all 0",
               reg_valid_o, reg_addr_o, reg_wdata_o, reg_wstrb_o, busy_o);
    end
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || reg_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: busy=%b valid=%b, want 0 0", busy_o, reg_valid_o);
    end
    slv_delay = 0;
    log_q.delete();
    start_and_wait(lat);
    push_cfg();
    idx = first_diff();
    checks++;
    if (idx !== -1 || lat !== exp_lat(0, 3, 0)) begin
      errors++;
      $display("FAIL midrst_restart: entry %0d got %h want %h, %0d cycles want %0d",
               idx, log_at(idx), exp_at(idx), lat, exp_lat(0, 3, 0));
    end
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    irq_i = 1'b0;
    rst_ack_i = 1'b0;
    test_reset();
    test_config_zero_wait();
    test_config_wait();
    test_retry();
    test_fatal();
    test_irq();
    test_back_to_back_irq();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
